clip_refresh_sched: RTL and testbench

Frame-refresh scheduler for the clipping pipeline. It arbitrates object-memory ownership between the matrix unit and the clipper, and snapshots the 32-entry object map at refresh start. It then sequences the per-object read slots that drive the line handler, and tracks lines in flight through the clip path so it can report frame completion. It sits between the matrix unit and the clipper's line handler/FIFO path.

---
 rtl/clip_refresh_sched_if.sv | 40 ++++
 rtl/clip_refresh_sched.sv | 132 +++++++++++++
 tb/tb_clip_refresh_sched.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/clip_refresh_sched_if.sv
// Bus between the matrix unit / line handler side and the refresh scheduler.
interface clip_refresh_sched_if #(
  parameter int NUM_OBJ = 32,
  parameter int ADDR_W  = 5
);
  logic [NUM_OBJ-1:0] obj_map;
  logic               changed;
  logic               writing;
  logic               raster_idle;
  logic               lines_in;
  logic               lines_done;
  logic               reading;
  logic               start_refresh;
  logic               clr_changed;
  logic [ADDR_W-1:0]  addr;
  logic               read_en;
  logic               cycle_1;
  logic               cycle_2;
  logic               cycle_3;
  logic               cycle_4;
  logic               obj_vld;
  logic               prev_obj_vld;
  logic               frame_done;
  logic               busy;
  logic               err;

  modport slave (
    input  obj_map, changed, writing, raster_idle, lines_in, lines_done,
    output reading, start_refresh, clr_changed, addr, read_en,
           cycle_1, cycle_2, cycle_3, cycle_4, obj_vld, prev_obj_vld,
           frame_done, busy, err
  );

  modport master (
    output obj_map, changed, writing, raster_idle, lines_in, lines_done,
    input  reading, start_refresh, clr_changed, addr, read_en,
           cycle_1, cycle_2, cycle_3, cycle_4, obj_vld, prev_obj_vld,
           frame_done, busy, err
  );
endinterface

// File: rtl/clip_refresh_sched.sv
// Frame-refresh scheduler: owns object memory for the clipper during a
// refresh, scans a snapshot of the object map in 4-cycle / 1-cycle slots,
// then waits for all in-flight lines to retire before signalling frame_done.
//
// state | meaning
// IDLE  | matrix unit owns object memory, waiting for changed && !writing
// SCAN  | stepping addr over the snapshot, one slot per object
// DRAIN | scan finished, waiting for lines in flight and rasterizer to empty
// DONE  | one-cycle frame_done, ownership already returned
module clip_refresh_sched #(
  parameter int NUM_OBJ = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 8
) (
  input logic                clk,
  input logic                rst_n,
  clip_refresh_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt, addr_inc;
  logic [3:0]         ph_q, ph_nxt;
  logic [NUM_OBJ-1:0] snap_q, snap_nxt;
  logic               start_q, start_nxt;
  logic               done_q, done_nxt;
  logic               reading_q, busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               slot_end;

  assign addr_inc = addr_q + ADDR_W'(1);
  // A skip slot has no phase bit set; a full slot ends on its fourth phase.
  assign slot_end = (ph_q == 4'b0000) || ph_q[3];

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      ph_q      <= '0;
      snap_q    <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      reading_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      ph_q      <= ph_nxt;
      snap_q    <= snap_nxt;
      start_q   <= start_nxt;
      done_q    <= done_nxt;
      reading_q <= (state_nxt == SCAN) || (state_nxt == DRAIN);
      busy_q    <= (state_nxt != IDLE);
    end
  end

  // Next-state, slot sequencing and snapshot capture.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    ph_nxt    = ph_q;
    snap_nxt  = snap_q;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.changed && !bus.writing) begin
          state_nxt = SCAN;
          snap_nxt  = bus.obj_map;
          addr_nxt  = '0;
          ph_nxt    = bus.obj_map[0] ? 4'b0001 : 4'b0000;
          start_nxt = 1'b1;
        end
      end
      SCAN: begin
        if (slot_end) begin
          if (addr_q == ADDR_W'(NUM_OBJ - 1)) begin
            state_nxt = DRAIN;
            addr_nxt  = '0;
            ph_nxt    = '0;
          end else begin
            addr_nxt = addr_inc;
            ph_nxt   = snap_q[addr_inc] ? 4'b0001 : 4'b0000;
          end
        end else begin
          ph_nxt = ph_q << 1;
        end
      end
      DRAIN: begin
        if ((cnt_q == '0) && bus.raster_idle && !bus.lines_in) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lines-in-flight counter; saturates at both ends and flags the misuse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (bus.lines_in && !bus.lines_done) begin
      if (cnt_q == '1) err_q <= 1'b1;
      else             cnt_q <= cnt_q + CNT_W'(1);
    end else if (!bus.lines_in && bus.lines_done) begin
      if (cnt_q == '0) err_q <= 1'b1;
      else             cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign bus.reading       = reading_q;
  assign bus.start_refresh = start_q;
  assign bus.clr_changed   = start_q;
  assign bus.addr          = addr_q;
  assign bus.cycle_1       = ph_q[0];
  assign bus.cycle_2       = ph_q[1];
  assign bus.cycle_3       = ph_q[2];
  assign bus.cycle_4       = ph_q[3];
  assign bus.read_en       = (state == SCAN) && ph_q[0];
  assign bus.obj_vld       = (state == SCAN) && snap_q[addr_q];
  assign bus.prev_obj_vld  = (addr_q != '0) && snap_q[addr_q - ADDR_W'(1)];
  assign bus.frame_done    = done_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_clip_refresh_sched.sv
// Directed bench for clip_refresh_sched with hand-computed expectations.
module tb_clip_refresh_sched;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  clip_refresh_sched_if #(.NUM_OBJ(32), .ADDR_W(5)) bus ();

  clip_refresh_sched #(.NUM_OBJ(32), .ADDR_W(5), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cyc();
    return {bus.cycle_4, bus.cycle_3, bus.cycle_2, bus.cycle_1};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.obj_map = '0; bus.changed = 0; bus.writing = 0;
    bus.raster_idle = 0; bus.lines_in = 0; bus.lines_done = 0;
    #23;
    chk("rst_reading", bus.reading, 0);
    chk("rst_start", bus.start_refresh, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_cyc", cyc(), 0);
    chk("rst_fdone", bus.frame_done, 0);
    rst_n = 1'b1;

    // Basic refresh with a single object at addr 0
    tick();
    bus.obj_map = 32'h0000_0001; bus.changed = 1;
    tick();
    chk("t1_start", bus.start_refresh, 1);
    chk("t1_clr", bus.clr_changed, 1);
    chk("t1_reading", bus.reading, 1);
    chk("t1_addr0", bus.addr, 0);
    chk("t1_cyc1", cyc(), 4'b0001);
    chk("t1_read_en", bus.read_en, 1);
    chk("t1_obj_vld", bus.obj_vld, 1);
    chk("t1_prev0", bus.prev_obj_vld, 0);
    chk("t1_busy", bus.busy, 1);
    bus.changed = 0;
    tick();
    chk("t1_start_pulse", bus.start_refresh, 0);
    chk("t1_clr_pulse", bus.clr_changed, 0);
    chk("t1_cyc2", cyc(), 4'b0010);
    chk("t1_read_en_c2", bus.read_en, 0);
    tick(); tick();
    chk("t1_cyc4", cyc(), 4'b1000);
    tick();
    chk("t1_addr1", bus.addr, 1);
    chk("t1_skip_cyc", cyc(), 0);
    chk("t1_skip_vld", bus.obj_vld, 0);
    chk("t1_prev1", bus.prev_obj_vld, 1);
    repeat (30) tick();
    chk("t1_addr31", bus.addr, 31);
    chk("t1_scan_reading", bus.reading, 1);
    tick();
    chk("t1_drain_addr", bus.addr, 0);
    chk("t1_drain_reading", bus.reading, 1);
    chk("t1_drain_vld", bus.obj_vld, 0);
    bus.lines_in = 1;
    tick(); tick();
    bus.lines_in = 0; bus.lines_done = 1;
    tick(); tick();
    bus.lines_done = 0;
    tick();
    chk("t1_wait_busy", bus.busy, 1);
    chk("t1_wait_fdone", bus.frame_done, 0);
    bus.lines_in = 1; bus.lines_done = 1;
    tick();
    bus.lines_in = 0; bus.lines_done = 0;
    chk("t1_both_err", bus.err, 0);
    tick();
    chk("t1_no_idle_fdone", bus.frame_done, 0);
    bus.raster_idle = 1;
    tick();
    chk("t1_fdone", bus.frame_done, 1);
    chk("t1_done_reading", bus.reading, 0);
    chk("t1_done_busy", bus.busy, 1);
    tick();
    chk("t1_fdone_pulse", bus.frame_done, 0);
    chk("t1_idle_busy", bus.busy, 0);

    // Start blocked by writing
    bus.obj_map = 0; bus.changed = 1; bus.writing = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_blocked", bus.start_refresh, 0);
    end
    bus.writing = 0;
    tick();
    chk("t2_start", bus.start_refresh, 1);
    chk("t2_reading", bus.reading, 1);
    chk("t2_cyc_zero", cyc(), 0);
    chk("t2_read_en", bus.read_en, 0);
    bus.changed = 0;
    repeat (31) tick();
    chk("t2_addr31", bus.addr, 31);
    chk("t2_scan_reading", bus.reading, 1);
    tick();
    chk("t2_drain_fdone", bus.frame_done, 0);
    tick();
    chk("t2_fdone", bus.frame_done, 1);
    tick();
    chk("t2_idle", bus.busy, 0);

    // Full map, snapshot isolation, and re-request during SCAN
    bus.obj_map = 32'hFFFF_FFFF; bus.changed = 1;
    tick();
    chk("t3_start", bus.start_refresh, 1);
    bus.changed = 0; bus.obj_map = 0;
    for (int k = 1; k <= 128; k++) begin
      if (k == 10) bus.changed = 1;
      chk("t3_addr", bus.addr, 32'((k - 1) / 4));
      chk("t3_vld", bus.obj_vld, 1);
      chk("t3_cyc", cyc(), 32'(1) << ((k - 1) % 4));
      tick();
    end
    chk("t3_D_reading", bus.reading, 1);
    chk("t3_D_start", bus.start_refresh, 0);
    bus.obj_map = 32'h0000_0080;
    tick();
    chk("t3_D1_fdone", bus.frame_done, 1);
    chk("t3_D1_start", bus.start_refresh, 0);
    tick();
    chk("t3_D2_start", bus.start_refresh, 0);
    chk("t3_D2_reading", bus.reading, 0);
    tick();
    chk("t3_D3_start", bus.start_refresh, 1);
    chk("t3_D3_clr", bus.clr_changed, 1);
    bus.changed = 0;

    // Asynchronous reset mid-SCAN at addr 7
    repeat (7) tick();
    chk("t4_addr7", bus.addr, 7);
    chk("t4_cyc1", cyc(), 4'b0001);
    tick();
    chk("t4_cyc2", cyc(), 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_reading", bus.reading, 0);
    chk("t4_rst_busy", bus.busy, 0);
    chk("t4_rst_addr", bus.addr, 0);
    chk("t4_rst_cyc", cyc(), 0);
    #2 rst_n = 1'b1;

    // Underflow sets sticky err; restart begins at addr 0
    tick();
    bus.lines_done = 1;
    tick();
    bus.lines_done = 0;
    chk("t5_err_set", bus.err, 1);
    tick();
    chk("t5_err_sticky", bus.err, 1);
    bus.lines_in = 1;
    tick();
    bus.lines_in = 0;
    chk("t5_err_sticky2", bus.err, 1);
    bus.changed = 1; bus.obj_map = 32'h0000_0080;
    tick();
    chk("t5_start", bus.start_refresh, 1);
    chk("t5_addr0", bus.addr, 0);
    chk("t5_vld0", bus.obj_vld, 0);
    bus.changed = 0;
    repeat (7) tick();
    chk("t5_addr7", bus.addr, 7);
    chk("t5_cyc1", cyc(), 4'b0001);
    chk("t5_prev7", bus.prev_obj_vld, 0);
    repeat (4) tick();
    chk("t5_addr8", bus.addr, 8);
    chk("t5_prev8", bus.prev_obj_vld, 1);
    repeat (24) tick();
    tick(); tick();
    chk("t5_wait_cnt", bus.frame_done, 0);
    chk("t5_wait_busy", bus.busy, 1);
    bus.lines_done = 1;
    tick();
    bus.lines_done = 0;
    chk("t5_err_kept", bus.err, 1);
    tick();
    chk("t5_fdone", bus.frame_done, 1);
    tick();
    chk("t5_idle", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
